fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/VALID/DROP handshake between imem and decode.
// Optional macro FETCH_DELAY_SLOT_EN turns redirects into delayed (delay-slot) redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n, drop_addr, drop_addr_n;
  logic [31:0] tgt, seq_pc;
  logic        kill, accept;

  assign tgt    = target & ~32'd3;
  assign accept = (state == VALID) && instr_ready && !stall;

`ifdef FETCH_DELAY_SLOT_EN
  logic        pend_vld, pend_vld_n;
  logic [31:0] pend_tgt, pend_tgt_n;

  // The instruction in flight is the delay slot; the redirect lands on its acceptance.
  assign kill   = 1'b0;
  assign seq_pc = pend_vld ? pend_tgt : (redirect ? tgt : pc + 32'd4);

  always_comb begin
    pend_vld_n = pend_vld;
    pend_tgt_n = pend_tgt;
    if (accept) begin
      pend_vld_n = 1'b0;
    end else if (redirect && !pend_vld) begin
      pend_vld_n = 1'b1;
      pend_tgt_n = tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else begin
      pend_vld <= pend_vld_n;
      pend_tgt <= pend_tgt_n;
    end
  end
`else
  assign kill   = redirect;
  assign seq_pc = pc + 32'd4;
`endif

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_n     = instr;
    drop_addr_n = drop_addr;
    case (state)
      IDLE: begin
        state_n = FETCH;
        if (kill) pc_n = tgt;
      end
      FETCH: begin
        if (kill) begin
          // Without an ack the old request is still outstanding and must be drained.
          pc_n        = tgt;
          drop_addr_n = pc;
          state_n     = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = VALID;
        end
      end
      VALID: begin
        if (kill) begin
          pc_n    = tgt;
          state_n = FETCH;
        end else if (accept) begin
          pc_n    = seq_pc;
          state_n = FETCH;
        end
      end
      DROP: begin
        if (kill)     pc_n    = tgt;
        if (imem_ack) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      drop_addr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr     <= instr_n;
      drop_addr <= drop_addr_n;
    end
  end

  assign imem_req    = (state == FETCH) || (state == DROP);
  assign imem_addr   = (state == DROP) ? drop_addr : pc;
  assign instr_valid = (state == VALID);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences, random vs. PC-stream model.
module tb_fetch_ctrl;
  localparam logic [31:0] RP = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n, redirect, stall, imem_ack, instr_ready;
  logic        imem_req, instr_valid;
  logic [31:0] target, imem_addr, imem_rdata, instr, pc;
  int tests = 0, fails = 0;

  fetch_ctrl #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .target(target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic        ack, ready, stall;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'd17;
  endfunction

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic stl, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.stall = stl;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in;
    redirect = 0; target = '0; stall = 0; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
  endtask

  task automatic do_reset;
    idle_in();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  vec_t tv[$];

  initial begin
    logic        seen, acc, pend_v;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr, exp_pc, pend_t;
    int          accepts;

    idle_in();
    rst_n = 0;
    @(negedge clk);

    // Reset release, 2-cycle ack, then decode backpressure and stall hold.
    tv.push_back(mk(0, 0,            0, 0, 0, 0,            0, RP,           0));
    tv.push_back(mk(0, 0,            0, 0, 1, 32'h3000,     0, 32'h3000,     0));
    tv.push_back(mk(1, 32'h1111_1111, 0, 0, 1, 32'h3000,    0, 32'h3000,     0));
    tv.push_back(mk(0, 0,            1, 0, 0, 0,            1, 32'h3000,     32'h1111_1111));
    tv.push_back(mk(0, 0,            0, 0, 1, 32'h3004,     0, 32'h3004,     0));
    tv.push_back(mk(1, 32'h2222_2222, 0, 0, 1, 32'h3004,    0, 32'h3004,     0));
    tv.push_back(mk(0, 0,            1, 0, 0, 0,            1, 32'h3004,     32'h2222_2222));
    tv.push_back(mk(0, 0,            0, 0, 1, 32'h3008,     0, 32'h3008,     0));
    tv.push_back(mk(1, 32'h3333_3333, 0, 0, 1, 32'h3008,    0, 32'h3008,     0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0,          0, 0, 0, 0,            1, 32'h3008,     32'h3333_3333));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0,          1, 1, 0, 0,            1, 32'h3008,     32'h3333_3333));
    tv.push_back(mk(0, 0,            1, 0, 0, 0,            1, 32'h3008,     32'h3333_3333));
    tv.push_back(mk(0, 0,            0, 0, 1, 32'h300C,     0, 32'h300C,     0));

    do_reset();
    foreach (tv[i]) begin
      imem_ack = tv[i].ack; imem_rdata = tv[i].rdata;
      instr_ready = tv[i].ready; stall = tv[i].stall;
      chk($sformatf("vec%0d_req", i), imem_req, tv[i].e_req);
      if (tv[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_valid", i), instr_valid, tv[i].e_valid);
      chk($sformatf("vec%0d_pc", i), pc, tv[i].e_pc);
      if (tv[i].e_valid) chk($sformatf("vec%0d_instr", i), instr, tv[i].e_instr);
      cyc();
    end

    // Reset while a fetch is outstanding; the late ack lands in IDLE and is dropped.
    idle_in();
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rst_pc", pc, RP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    idle_in();
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_addr", imem_addr, RP);
    cyc();
    chk("late_ack_valid2", instr_valid, 0);

`ifdef FETCH_DELAY_SLOT_EN
    // Delay slot: 0x3008 still completes, then the fetch jumps to 0x3100.
    imem_ack = 1; imem_rdata = 32'hA000_0000; cyc();
    idle_in(); instr_ready = 1; cyc();
    idle_in(); imem_ack = 1; imem_rdata = 32'hA000_0004; cyc();
    idle_in(); instr_ready = 1; cyc();
    idle_in(); imem_ack = 1; imem_rdata = 32'hA000_0008; cyc();
    idle_in();
    chk("ds_valid", instr_valid, 1);
    chk("ds_pc", pc, 32'h3008);
    redirect = 1; target = 32'h3100;
    cyc();
    idle_in();
    chk("ds_hold_valid", instr_valid, 1);
    chk("ds_hold_pc", pc, 32'h3008);
    chk("ds_hold_instr", instr, 32'hA000_0008);
    instr_ready = 1;
    cyc();
    idle_in();
    chk("ds_next_req", imem_req, 1);
    chk("ds_next_addr", imem_addr, 32'h3100);
`else
    // Redirect one cycle before the ack: old data must be drained, never presented.
    redirect = 1; target = 32'h3100;
    cyc();
    idle_in();
    chk("drop_req", imem_req, 1);
    chk("drop_addr_old", imem_addr, RP);
    chk("drop_pc", pc, 32'h3100);
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    idle_in();
    chk("drop_valid", instr_valid, 0);
    chk("drop_next_addr", imem_addr, 32'h3100);
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    cyc();
    idle_in();
    chk("drop_new_valid", instr_valid, 1);
    chk("drop_new_instr", instr, 32'h1234_5678);
    chk("drop_new_pc", pc, 32'h3100);
`endif

    // PC wrap from the top of the address space.
    do_reset();
    cyc();
    redirect = 1; target = 32'hFFFF_FFFC;
    cyc();
    idle_in();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      imem_ack = imem_req; imem_rdata = mem(imem_addr); instr_ready = 1;
      if (instr_valid && pc == 32'hFFFF_FFFC) seen = 1;
      cyc();
    end
    idle_in();
    chk("wrap_seen", seen, 1);
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Random traffic against the expected stream of accepted PCs.
    do_reset();
    exp_pc = RP; pend_v = 0; pend_t = '0; accepts = 0;
    prev_req = 0; prev_ack = 0; prev_addr = '0;
    for (int n = 0; n < 4000; n++) begin
      if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
      redirect    = (imem_req || instr_valid) && ($urandom % 10 == 0);
      target      = $urandom;
      stall       = ($urandom % 4 == 0);
      instr_ready = $urandom % 2;
      imem_ack    = imem_req && ($urandom % 3 == 0);
      imem_rdata  = imem_ack ? mem(imem_addr) : $urandom;
`ifdef FETCH_DELAY_SLOT_EN
      if (redirect && !pend_v) begin pend_v = 1; pend_t = target & ~32'd3; end
      acc = instr_valid && instr_ready && !stall;
      if (acc) begin
        chk("rand_pc", pc, exp_pc);
        chk("rand_instr", instr, mem(exp_pc));
        exp_pc = pend_v ? pend_t : exp_pc + 32'd4;
        pend_v = 0;
        accepts++;
      end
`else
      acc = instr_valid && instr_ready && !stall && !redirect;
      if (redirect) exp_pc = target & ~32'd3;
      else if (acc) begin
        chk("rand_pc", pc, exp_pc);
        chk("rand_instr", instr, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
`endif
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      cyc();
    end
    idle_in();
    chk("rand_progress", accepts > 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
